// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_if
// Description : Operation-in / result-out handshake bundle for alu_pipe.
//               The slave modport is the ALU side; the master modport is the
//               producer/consumer side that drives operations and accepts
//               results.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  flag_zero;
    logic                  flag_neg;
    logic                  flag_carry;
    logic                  flag_ovf;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined integer ALU with valid/ready flow control.
//               Stage 1 captures op/a/b, stage 2 computes and registers the
//               result with zero/neg/carry/ovf flags. Full backpressure,
//               no skid buffer: in_ready is combinational from out_ready.
//               Optional macro ALU_PIPE_SAT_EN: ADD/SUB saturate to the
//               signed limits on overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   reset,
    alu_pipe_if.slave   bus
);
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    localparam logic [2:0] c_op_add   = 3'd0;
    localparam logic [2:0] c_op_sub   = 3'd1;
    localparam logic [2:0] c_op_not_a = 3'd2;
    localparam logic [2:0] c_op_and   = 3'd3;
    localparam logic [2:0] c_op_or    = 3'd4;
    localparam logic [2:0] c_op_xor   = 3'd5;
    localparam logic [2:0] c_op_shl   = 3'd6;
    localparam logic [2:0] c_op_shr   = 3'd7;

    localparam int MSB = DATA_WIDTH - 1;

    // Stage 1: captured operation
    logic                  s1_valid_q, s1_valid_d;
    logic [2:0]            s1_op_q,    s1_op_d;
    logic [DATA_WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [DATA_WIDTH-1:0] s1_b_q,     s1_b_d;

    // Stage 2: registered result and flags
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] result_q,   result_d;
    logic                  zero_q,     zero_d;
    logic                  neg_q,      neg_d;
    logic                  carry_q,    carry_d;
    logic                  ovf_q,      ovf_d;

    // Combinational datapath
    logic                  w_s1_adv;
    logic                  w_s2_adv;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic                  w_alu_carry;
    logic                  w_alu_ovf;

    // ALU operation on the stage-1 operands; flags use the final result
    always_comb begin
        w_sum       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        w_diff      = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
        w_shamt     = s1_b_q[SHAMT_WIDTH-1:0];
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        case (s1_op_q)
            c_op_add: begin
                w_alu_res   = w_sum[DATA_WIDTH-1:0];
                w_alu_carry = w_sum[DATA_WIDTH];
                w_alu_ovf   = (s1_a_q[MSB] == s1_b_q[MSB]) && (w_sum[MSB] != s1_a_q[MSB]);
            end
            c_op_sub: begin
                w_alu_res   = w_diff[DATA_WIDTH-1:0];
                // carry out of a + ~b + 1 is "no borrow"; the flag reports borrow
                w_alu_carry = !w_diff[DATA_WIDTH];
                w_alu_ovf   = (s1_a_q[MSB] != s1_b_q[MSB]) && (w_diff[MSB] != s1_a_q[MSB]);
            end
            c_op_not_a: w_alu_res = ~s1_a_q;
            c_op_and:   w_alu_res = s1_a_q & s1_b_q;
            c_op_or:    w_alu_res = s1_a_q | s1_b_q;
            c_op_xor:   w_alu_res = s1_a_q ^ s1_b_q;
            c_op_shl:   w_alu_res = s1_a_q << w_shamt;
            c_op_shr:   w_alu_res = s1_a_q >> w_shamt;
            default:    w_alu_res = '0;
        endcase
`ifdef ALU_PIPE_SAT_EN
        // Overflow direction follows the sign of a: positive a can only
        // overflow upward, negative a only downward, for both ADD and SUB.
        if (((s1_op_q == c_op_add) || (s1_op_q == c_op_sub)) && w_alu_ovf) begin
            w_alu_res = s1_a_q[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`endif
    end

    // Pipeline advance and next-state for both stages
    always_comb begin
        w_s2_adv   = !s2_valid_q || bus.out_ready;
        w_s1_adv   = !s1_valid_q || w_s2_adv;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;

        if (w_s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_op_d = bus.op;
                s1_a_d  = bus.a;
                s1_b_d  = bus.b;
            end
        end

        if (w_s2_adv) begin
            s2_valid_d = s1_valid_q;
            // data registers only move when a real op arrives, so the
            // presented result stays put while the output sits idle
            if (s1_valid_q) begin
                result_d = w_alu_res;
                zero_d   = (w_alu_res == '0);
                neg_d    = w_alu_res[MSB];
                carry_d  = w_alu_carry;
                ovf_d    = w_alu_ovf;
            end
        end
    end

    // Pipeline registers; reset discards every in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.in_ready   = w_s1_adv;
    assign bus.out_valid  = s2_valid_q;
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_neg   = neg_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, opcode-selected, two-stage pipelined integer ALU.
- Next generation of the team's combinational single-op ALU.
- Adds operation select, shifts, status flags and valid/ready flow control with full backpressure.
- Sits between a register-file read stage and a writeback or consumer block.

Parameters:
DATA_WIDTH, 32, operand/result width in bits; minimum 2; must be a power of two (shift amount width derives from it).
SHAMT_WIDTH, $clog2(DATA_WIDTH), derived; do not override.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation presented on op/a/b
in_ready  output  1  ALU accepts operation this cycle
op  input  3  opcode: 0 ADD, 1 SUB, 2 NOT_A, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR
a  input  DATA_WIDTH  operand A
b  input  DATA_WIDTH  operand B; for shifts only b[SHAMT_WIDTH-1:0] is used
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  DATA_WIDTH  operation result
flag_zero  output  1  result == 0
flag_neg  output  1  result[DATA_WIDTH-1]
flag_carry  output  1  ADD: carry out; SUB: borrow (a < b unsigned); else 0
flag_ovf  output  1  signed overflow for ADD/SUB; else 0

Behaviour:
- Reset (async assert, sync deassert by clk):
  - s1_valid, s2_valid, out_valid = 0.
  - result = 0; all flags = 0.
  - in_ready = 1 once reset is low.
- Handshake: transfer when valid && ready.
  - Inputs sampled only on in_valid && in_ready.
  - out_valid is never dropped until out_ready is seen.
  - result/flags are held stable while out_valid && !out_ready.
- Pipeline:
  - Stage 1 registers op/a/b.
  - Stage 2 computes and registers result + flags.
  - Latency: exactly 2 cycles from accept to out_valid when there is no backpressure.
  - Throughput: 1 op/cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
  - A stage with valid=0 never blocks.
- Capacity: at most 2 ops in flight. With out_ready held low, exactly 2 ops are accepted, then in_ready = 0.
- Ordering: results leave strictly in accept order.
- Arithmetic: all operations are modulo 2^DATA_WIDTH (except under the optional feature).
  - ADD is computed at DATA_WIDTH+1 bits; bit DATA_WIDTH is the carry.
  - SUB = a + ~b + 1; flag_carry = borrow = !carry_out.
  - ADD ovf = (a[msb] == b[msb]) && (sum[msb] != a[msb]).
  - SUB ovf = (a[msb] != b[msb]) && (diff[msb] != a[msb]).
  - SHL/SHR are logical, zero-filled; shift amount 0 passes a unchanged.
- Flags: flag_zero and flag_neg are computed from the final (possibly saturated) result and are registered with it.
- Simultaneous events: out_ready and in_valid in the same cycle with both stages full:
  - s2 drains, s1 moves to s2, and the new op enters s1.
  - No bubble, no loss.
- Reset mid-operation: all in-flight ops are discarded with no output. The first op after reset appears 2 cycles after its accept.
- No X propagation: registers on invalid stages may hold stale data, but out_valid gates their use.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined:
  - ADD/SUB saturate to the signed limits on overflow: positive overflow gives 0111..1, negative overflow gives 1000..0.
  - flag_ovf still reports that overflow occurred.
  - flag_carry is computed from the unsaturated operation.
- Not defined: ADD/SUB wrap modulo 2^DATA_WIDTH; there is no saturation logic.

Test Plan (DATA_WIDTH=8, out_ready=1 unless stated):
1. ADD a=0xFF b=0x01 -> 2 cycles later result=0x00, zero=1, carry=1, ovf=0, neg=0.
2. ADD a=0x7F b=0x01 -> result=0x80, ovf=1, neg=1, carry=0; with ALU_PIPE_SAT_EN -> result=0x7F, ovf=1, neg=0.
3. SUB a=0x80 b=0x01 -> result=0x7F, ovf=1, carry(borrow)=0; with SAT -> 0x80. SUB a=0x01 b=0x02 -> result=0xFF, carry=1, neg=1.
4. SHR a=0x80 b=0x0F (shamt=7) -> 0x01; SHL a=0x81 b=0x01 -> 0x02; NOT_A a=0x0F -> 0xF0; XOR 0xAA^0xAA -> 0x00, zero=1.
5. Backpressure: out_ready=0, stream ADD 1+1, 2+2, 3+3 -> in_ready falls after 2 accepts; the first result (0x02) is held stable; raise out_ready -> 0x02, 0x04, 0x06 in order, none lost or duplicated.
6. Reset mid-flight: accept 2 ops, assert reset for 1 cycle before either output -> out_valid=0, all outputs 0; the next op (AND 0xF0&0x3C) produces 0x30 exactly 2 cycles after accept.
